// File: rtl/btb_tagged_predictor.sv
// Tagged branch target buffer: combinational IF-stage lookup, registered EX-stage
// update with saturating direction counters, flush-all and saturating statistics.
module btb_tagged_predictor #(
   parameter int PC_W   = 32,
   parameter int DEPTH  = 32,
   parameter int TAG_W  = 8,
   parameter int CTR_W  = 2,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PC_W-1:0]   lu_pc,
   output logic              lu_hit,
   output logic              lu_taken,
   output logic [PC_W-1:0]   lu_target,
   output logic [CTR_W-1:0]  lu_ctr,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic              upd_taken,
   input  logic [PC_W-1:0]   upd_target,
   input  logic              upd_mispredict,
   input  logic              flush_all,
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispred
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   logic [DEPTH-1:0] valid_q;
   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [PC_W-1:0]  tgt_q [DEPTH];
   logic [CTR_W-1:0] ctr_q [DEPTH];
   logic [STAT_W-1:0] br_q;
   logic [STAT_W-1:0] mp_q;

   logic [IDX_W-1:0] lu_idx;
   logic [TAG_W-1:0] lu_tag;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;

   assign lu_idx  = lu_pc[IDX_W-1:0];
   assign lu_tag  = lu_pc[IDX_W +: TAG_W];
   assign upd_idx = upd_pc[IDX_W-1:0];
   assign upd_tag = upd_pc[IDX_W +: TAG_W];

   // PC bits above the tag deliberately alias onto the same entry.
   generate
      if (IDX_W + TAG_W < PC_W) begin : g_pc_hi
         logic unused_pc_hi;
         assign unused_pc_hi = ^{lu_pc[PC_W-1:IDX_W+TAG_W], upd_pc[PC_W-1:IDX_W+TAG_W]};
      end
   endgenerate

   // Lookup reads registered state only, so a same-cycle update is not bypassed.
   always_comb begin
      lu_hit    = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
      lu_taken  = lu_hit && ctr_q[lu_idx][CTR_W-1];
      lu_target = lu_hit ? tgt_q[lu_idx] : '0;
      lu_ctr    = ctr_q[lu_idx];
   end

   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   // upd_valid is a one-cycle qualifier with no back-pressure: every asserted
   // cycle is consumed at that rising edge, and there is no ready signal.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= CTR_WNT;
         end
      end else if (flush_all) begin
         valid_q <= '0;
      end else if (upd_valid) begin
         if (upd_hit) begin
            if (upd_taken) begin
               if (ctr_q[upd_idx] != CTR_MAX)
                  ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_W'(1);
               tgt_q[upd_idx] <= upd_target;
            end else if (ctr_q[upd_idx] != '0) begin
               ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_W'(1);
            end
         end else if (upd_taken) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            tgt_q[upd_idx]   <= upd_target;
            ctr_q[upd_idx]   <= CTR_WT;
         end
      end
   end

   // Statistics ignore flush_all; stat_clr beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         br_q <= '0;
         mp_q <= '0;
      end else if (upd_valid) begin
         if (br_q != STAT_MAX)
            br_q <= br_q + STAT_W'(1);
         if (upd_mispredict && (mp_q != STAT_MAX))
            mp_q <= mp_q + STAT_W'(1);
      end
   end

   assign stat_branches = br_q;
   assign stat_mispred  = mp_q;

endmodule

// File: tb/tb_btb_tagged_predictor.sv
// Bench for btb_tagged_predictor: directed scenarios followed by random traffic,
// all compared against an array-based model of the table and statistics.
module tb_btb_tagged_predictor;

   localparam int PC_W   = 32;
   localparam int DEPTH  = 32;
   localparam int TAG_W  = 8;
   localparam int CTR_W  = 2;
   localparam int STAT_W = 4;
   localparam int CMAX   = (1 << CTR_W) - 1;
   localparam int CWT    = 1 << (CTR_W - 1);
   localparam int SMAX   = (1 << STAT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [PC_W-1:0]   lu_pc;
   logic              lu_hit;
   logic              lu_taken;
   logic [PC_W-1:0]   lu_target;
   logic [CTR_W-1:0]  lu_ctr;
   logic              upd_valid;
   logic [PC_W-1:0]   upd_pc;
   logic              upd_taken;
   logic [PC_W-1:0]   upd_target;
   logic              upd_mispredict;
   logic              flush_all;
   logic              stat_clr;
   logic [STAT_W-1:0] stat_branches;
   logic [STAT_W-1:0] stat_mispred;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_valid [DEPTH];
   int unsigned m_tag   [DEPTH];
   int unsigned m_tgt   [DEPTH];
   int          m_ctr   [DEPTH];
   int          m_br;
   int          m_mp;
   logic [PC_W-1:0] exp_q [$];

   btb_tagged_predictor #(
      .PC_W(PC_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .CTR_W(CTR_W), .STAT_W(STAT_W)
   ) dut (
      .clk(clk), .rst(rst), .lu_pc(lu_pc), .lu_hit(lu_hit), .lu_taken(lu_taken),
      .lu_target(lu_target), .lu_ctr(lu_ctr), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
      .flush_all(flush_all), .stat_clr(stat_clr), .stat_branches(stat_branches),
      .stat_mispred(stat_mispred)
   );

   // clock
   always #5 clk = ~clk;

   function automatic void m_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = 0;
         m_tgt[i]   = 0;
         m_ctr[i]   = CWT - 1;
      end
      m_br = 0;
      m_mp = 0;
   endfunction

   function automatic int unsigned idx_of(input int unsigned pc);
      return pc % DEPTH;
   endfunction

   function automatic int unsigned tag_of(input int unsigned pc);
      return (pc / DEPTH) % (1 << TAG_W);
   endfunction

   function automatic bit m_hit(input int unsigned pc);
      return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
   endfunction

   // Applies what the rising edge should do given the currently driven inputs.
   function automatic void m_edge();
      int unsigned i;
      if (rst) begin
         m_reset();
         return;
      end
      i = idx_of(upd_pc);
      if (flush_all) begin
         for (int k = 0; k < DEPTH; k++) m_valid[k] = 0;
      end else if (upd_valid) begin
         if (m_hit(upd_pc)) begin
            if (upd_taken) begin
               m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
               m_tgt[i] = upd_target;
            end else begin
               m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (upd_taken) begin
            m_valid[i] = 1;
            m_tag[i]   = tag_of(upd_pc);
            m_tgt[i]   = upd_target;
            m_ctr[i]   = CWT;
         end
      end
      if (stat_clr) begin
         m_br = 0;
         m_mp = 0;
      end else if (upd_valid) begin
         m_br = (m_br + 1 > SMAX) ? SMAX : m_br + 1;
         if (upd_mispredict) m_mp = (m_mp + 1 > SMAX) ? SMAX : m_mp + 1;
      end
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      m_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
      upd_mispredict = 0; flush_all = 0; stat_clr = 0;
   endtask

   task automatic drive_upd(input int unsigned pc, input bit taken, input int unsigned tgt,
                            input bit mis);
      upd_valid = 1; upd_pc = pc; upd_taken = taken; upd_target = tgt; upd_mispredict = mis;
   endtask

   task automatic do_upd(input int unsigned pc, input bit taken, input int unsigned tgt,
                         input bit mis);
      drive_upd(pc, taken, tgt, mis);
      tick();
      idle_inputs();
   endtask

   // scoreboard: model expectation is queued, then popped against the DUT
   task automatic check_lu(input string name, input int unsigned pc);
      bit h;
      logic [PC_W-1:0] exp_tgt;
      lu_pc = pc;
      #1;
      h = m_hit(pc);
      exp_q.push_back(h ? PC_W'(m_tgt[idx_of(pc)]) : '0);
      chk({name, "_hit"}, 64'(lu_hit), 64'(h));
      chk({name, "_taken"}, 64'(lu_taken), 64'(h && (m_ctr[idx_of(pc)] >= CWT)));
      chk({name, "_ctr"}, 64'(lu_ctr), 64'(m_ctr[idx_of(pc)]));
      exp_tgt = exp_q.pop_front();
      chk({name, "_target"}, 64'(lu_target), 64'(exp_tgt));
   endtask

   task automatic check_stats(input string name);
      chk({name, "_branches"}, 64'(stat_branches), 64'(m_br));
      chk({name, "_mispred"}, 64'(stat_mispred), 64'(m_mp));
   endtask

   initial begin
      idle_inputs();
      lu_pc = 0;
      m_reset();
      rst = 1;
      tick();
      tick();
      rst = 0;

      // reset state
      check_lu("rst_05", 32'h05);
      chk("rst_ctr_const", 64'(lu_ctr), 64'd1);
      check_stats("rst");

      // allocation and alias miss
      do_upd(32'h25, 1, 32'h40, 0);
      check_lu("alloc_25", 32'h25);
      chk("alloc_ctr_const", 64'(lu_ctr), 64'd2);
      chk("alloc_tgt_const", 64'(lu_target), 64'h40);
      check_lu("alias_45", 32'h45);
      chk("alias_miss_const", 64'(lu_hit), 64'd0);

      // counter saturation both ways
      for (int k = 0; k < 3; k++) do_upd(32'h25, 1, 32'h40, 0);
      check_lu("sat_hi", 32'h25);
      chk("sat_hi_const", 64'(lu_ctr), 64'd3);
      for (int k = 0; k < 2; k++) do_upd(32'h25, 0, 32'h99, 0);
      check_lu("dec_1", 32'h25);
      chk("dec_1_tgt_const", 64'(lu_target), 64'h40);
      for (int k = 0; k < 2; k++) do_upd(32'h25, 0, 32'h99, 0);
      check_lu("sat_lo", 32'h25);
      chk("sat_lo_const", 64'(lu_ctr), 64'd0);

      // same-cycle lookup sees old contents
      drive_upd(32'h25, 1, 32'h60, 0);
      check_lu("nobypass", 32'h25);
      chk("nobypass_const", 64'(lu_target), 64'h40);
      tick();
      idle_inputs();
      check_lu("after_upd", 32'h25);
      chk("after_upd_const", 64'(lu_target), 64'h60);

      // not-taken miss does not allocate; alias replaces
      do_upd(32'h07, 0, 32'h70, 0);
      check_lu("nt_miss_07", 32'h07);
      do_upd(32'h45, 1, 32'h80, 0);
      check_lu("repl_45", 32'h45);
      check_lu("repl_25", 32'h25);

      // flush wins over a simultaneous update, stats still count
      flush_all = 1;
      drive_upd(32'h09, 1, 32'h90, 0);
      tick();
      idle_inputs();
      check_lu("flush_09", 32'h09);
      check_lu("flush_45", 32'h45);
      check_stats("flush");
      chk("flush_br_const", 64'(stat_branches), 64'd12);

      // statistics saturation at 4 bits
      rst = 1;
      tick();
      rst = 0;
      for (int k = 0; k < 20; k++) do_upd(32'h100 + k, k[0], 32'h200 + k, 1);
      check_stats("stat_sat");
      chk("stat_sat_const", 64'(stat_mispred), 64'd15);
      stat_clr = 1;
      drive_upd(32'h3, 1, 32'h33, 1);
      tick();
      idle_inputs();
      check_stats("stat_clr");

      // reset mid-sequence
      do_upd(32'h12, 1, 32'h1234, 1);
      rst = 1;
      drive_upd(32'h13, 1, 32'h1313, 1);
      tick();
      idle_inputs();
      check_lu("midrst_12", 32'h12);
      check_lu("midrst_13", 32'h13);
      check_stats("midrst");

      // random traffic with lookups checked before each edge
      for (int n = 0; n < 400; n++) begin
         rst            = ($urandom_range(0, 199) == 0);
         flush_all      = ($urandom_range(0, 39) == 0);
         stat_clr       = ($urandom_range(0, 29) == 0);
         upd_valid      = ($urandom_range(0, 2) != 0);
         upd_pc         = $urandom_range(0, 127);
         upd_taken      = ($urandom_range(0, 2) != 0);
         upd_target     = $urandom;
         upd_mispredict = $urandom_range(0, 1);
         check_lu("rnd", $urandom_range(0, 127));
         check_stats("rnd");
         tick();
      end
      idle_inputs();
      check_stats("end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
